// File: rtl/instr_loader_pkg.sv
// Shared constants for the MIPS instruction loader: HALT opcode, FSM state encoding, default widths.
// The optional LOADER_CHECKSUM_EN build adds the CHECK state (its encoding is always reserved here).
package instr_loader_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam logic [5:0] OPCODE_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_CHECK    = 3'd3,
    ST_RST_PIPE = 3'd4,
    ST_RUN      = 3'd5,
    ST_ERROR    = 3'd6
  } loader_state_e;

  function automatic logic is_halt_op(input logic [5:0] op);
    return op == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs the byte stream (MSB byte first) into instruction words and flags each completed word.
// With LOADER_CHECKSUM_EN it also keeps a running XOR of every byte shifted in.
module instr_loader_word_assembler
  import instr_loader_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [7:0]         i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]         o_xor
`endif
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  logic [IDX_W-1:0]   r_idx;
  logic [NB_DATA-1:0] r_word;

  assign o_word_done = i_accept && (r_idx == IDX_W'(NB_BYTES - 1));
  assign o_word      = r_word;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_accept) begin
      r_word <= {r_word[NB_DATA-9:0], i_byte};
      r_idx  <= o_word_done ? '0 : r_idx + IDX_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  assign o_xor = r_xor;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_xor <= '0;
    else if (i_clear)  r_xor <= '0;
    else if (i_accept) r_xor <= r_xor ^ i_byte;
  end
`endif

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader driving the IF instruction-memory write port, then releasing the pipeline.
// States: IDLE, RECV, WRITE, [CHECK with LOADER_CHECKSUM_EN], RST_PIPE, RUN, ERROR.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int               NB_DATA          = NB_DATA_DEF,
  parameter int               NB_ADDR          = 32,
  parameter logic [NB_ADDR-1:0] BASE_ADDR      = '0,
  parameter int               ADDR_STEP        = 4,
  parameter int               MAX_WORDS        = 256,
  parameter int               RST_PULSE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_load_start,
  input  logic                      i_byte_valid,
  input  logic [7:0]                i_byte,
  output logic                      o_byte_ready,
  output logic                      o_we_IF,
  output logic [NB_ADDR-1:0]        o_inst_addr,
  output logic [NB_DATA-1:0]        o_instruction_data,
  output logic                      o_pipe_rst_n,
  output logic                      o_halt,
  output logic                      o_done,
  output logic                      o_error,
  output logic [$clog2(MAX_WORDS):0] o_word_count
);

  localparam int NB_CNT = $clog2(MAX_WORDS) + 1;
  localparam int NB_PLS = $clog2(RST_PULSE_CYCLES + 1);

  loader_state_e       r_state, w_next;
  logic [NB_PLS-1:0]   r_pulse;
  logic                w_xfer, w_accept, w_clear, w_word_done;
  logic [NB_DATA-1:0]  w_word;
  logic                w_ready, w_we, w_pipe_rst_n, w_halt, w_done, w_error;

  assign w_xfer   = i_byte_valid && o_byte_ready;
  assign w_accept = w_xfer && (r_state == ST_RECV);
  assign w_clear  = i_load_start &&
                    (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_ERROR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] w_xor;
`endif

  instr_loader_word_assembler #(.NB_DATA(NB_DATA)) u_asm (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_byte      (i_byte),
    .o_word      (w_word),
    .o_word_done (w_word_done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_xor       (w_xor)
`endif
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: if (i_load_start) w_next = ST_RECV;
      ST_RECV:                   if (w_word_done) w_next = ST_WRITE;
      ST_WRITE: begin
        if (is_halt_op(w_word[NB_DATA-1 -: 6])) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = ST_RST_PIPE;
`endif
        end else if (o_word_count == NB_CNT'(MAX_WORDS - 1)) begin
          w_next = ST_ERROR;
        end else begin
          w_next = ST_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: if (w_xfer) w_next = (i_byte == w_xor) ? ST_RST_PIPE : ST_ERROR;
`endif
      ST_RST_PIPE: if (r_pulse == '0) w_next = ST_RUN;
      default:     w_next = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    w_ready      = (w_next == ST_RECV) || (w_next == ST_CHECK);
    w_we         = (w_next == ST_WRITE);
    w_pipe_rst_n = (w_next != ST_RST_PIPE);
    w_halt       = (w_next != ST_RUN);
    w_done       = (w_next == ST_RUN);
    w_error      = (w_next == ST_ERROR);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_byte_ready <= 1'b0;
      o_we_IF      <= 1'b0;
      o_pipe_rst_n <= 1'b0;
      o_halt       <= 1'b1;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_byte_ready <= w_ready;
      o_we_IF      <= w_we;
      o_pipe_rst_n <= w_pipe_rst_n;
      o_halt       <= w_halt;
      o_done       <= w_done;
      o_error      <= w_error;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst_addr  <= BASE_ADDR;
      o_word_count <= '0;
    end else if (w_clear) begin
      o_inst_addr  <= BASE_ADDR;
      o_word_count <= '0;
    end else if (r_state == ST_WRITE) begin
      o_inst_addr  <= o_inst_addr + NB_ADDR'(ADDR_STEP);
      o_word_count <= o_word_count + NB_CNT'(1);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_pulse <= '0;
    else if (r_state != ST_RST_PIPE && w_next == ST_RST_PIPE)
      r_pulse <= NB_PLS'(RST_PULSE_CYCLES - 1);
    else if (r_state == ST_RST_PIPE && r_pulse != '0)
      r_pulse <= r_pulse - NB_PLS'(1);
  end

  assign o_instruction_data = w_word;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random byte programs checked against a word-level reference model.
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
module tb_instr_loader;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        bvalid = 1'b0;
  logic [7:0]  bdata = 8'h00;
  logic        o_byte_ready, o_we_IF, o_pipe_rst_n, o_halt, o_done, o_error;
  logic [31:0] o_inst_addr, o_instruction_data;
  logic [2:0]  o_word_count;

  always #5 clk = ~clk;

  instr_loader #(.MAX_WORDS(MAXW)) dut (
    .clk                (clk),
    .i_rst_n            (rst_n),
    .i_load_start       (load_start),
    .i_byte_valid       (bvalid),
    .i_byte             (bdata),
    .o_byte_ready       (o_byte_ready),
    .o_we_IF            (o_we_IF),
    .o_inst_addr        (o_inst_addr),
    .o_instruction_data (o_instruction_data),
    .o_pipe_rst_n       (o_pipe_rst_n),
    .o_halt             (o_halt),
    .o_done             (o_done),
    .o_error            (o_error),
    .o_word_count       (o_word_count)
  );

  int n_checks = 0;
  int n_err = 0;
  int low_cnt = 0;
  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  bit exp_halt, exp_err;

  always @(negedge clk) begin
    if (o_we_IF) begin
      got_addr.push_back(o_inst_addr);
      got_data.push_back(o_instruction_data);
    end
    if (rst_n && !o_pipe_rst_n) low_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: big-endian words at BASE+4*i, stop after HALT (written) or after MAXW words (error).
  task automatic model(input logic [7:0] q[$]);
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_halt = 0; exp_err = 0;
    for (int i = 0; i < q.size() / 4; i++) begin
      w = {q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]};
      exp_addr.push_back(32'(i * 4));
      exp_data.push_back(w);
      if (w[31:26] == 6'h3F) begin exp_halt = 1; break; end
      if (i + 1 == MAXW) begin exp_err = 1; break; end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bvalid = 1'b0;
    repeat (gap) @(negedge clk);
    bvalid = 1'b1;
    bdata  = b;
    while (!o_byte_ready && n < 100) begin @(negedge clk); n++; end
    if (!o_byte_ready) begin
      n_err++;
      $display("FAIL byte_ready_timeout: ready=%0b after %0d cycles, required 1", o_byte_ready, n);
    end
    n_checks++;
    @(negedge clk);
  endtask

  task automatic send_prog(input logic [7:0] q[$], input int maxgap, input bit bad_ck);
    logic [7:0] x = 8'h00;
    model(q);
    foreach (q[i]) begin
      send_byte(q[i], $urandom_range(maxgap));
      x ^= q[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (exp_halt) send_byte(x ^ {7'b0, bad_ck}, $urandom_range(maxgap));
`else
    if (bad_ck && exp_halt) x = 8'h00;
`endif
    bvalid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic push_word(inout logic [7:0] q[$], input logic [31:0] w);
    for (int k = 3; k >= 0; k--) q.push_back(w[8*k +: 8]);
  endtask

  function automatic logic [31:0] rand_plain();
    logic [31:0] w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_byte_ready, o_we_IF, o_pipe_rst_n, o_halt, o_done, o_error} !== 6'b000100) begin
      n_err++; $display("FAIL reset_flags: got %b want 000100",
        {o_byte_ready, o_we_IF, o_pipe_rst_n, o_halt, o_done, o_error});
    end
    n_checks++;
    if (o_inst_addr !== 32'h0 || o_instruction_data !== 32'h0 || o_word_count !== 3'd0) begin
      n_err++; $display("FAIL reset_regs: addr=%h data=%h cnt=%0d want 0/0/0",
        o_inst_addr, o_instruction_data, o_word_count);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_pipe_rst_n !== 1'b1 || o_halt !== 1'b1 || o_byte_ready !== 1'b0) begin
      n_err++; $display("FAIL post_reset: pipe_rst_n=%b halt=%b ready=%b want 1 1 0",
        o_pipe_rst_n, o_halt, o_byte_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q[$] = '{8'h20, 8'h01, 8'h00, 8'h0F, 8'hFC, 8'h00, 8'h00, 8'h00};
    logic [7:0] x = 8'h00;
    int g0 = got_addr.size();
    int l0 = low_cnt;
    int n = 0;
    model(q);
    start_load();
    n_checks++;
    if (o_byte_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", o_byte_ready); end
    foreach (q[i]) begin
      send_byte(q[i], 0);
      x ^= q[i];
      if (i % 4 == 3) begin
        n_checks++;
        if (o_we_IF !== 1'b1) begin n_err++; $display("FAIL basic_latency: we=%b want 1 (byte %0d)", o_we_IF, i); end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, 0);
`endif
    bvalid = 1'b0;
    while (!o_done && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (got_addr.size() - g0 != exp_addr.size()) begin
      n_err++; $display("FAIL basic_nwrites: got %0d want %0d", got_addr.size() - g0, exp_addr.size());
    end else foreach (exp_addr[i]) begin
      n_checks++;
      if (got_addr[g0+i] !== exp_addr[i] || got_data[g0+i] !== exp_data[i]) begin
        n_err++; $display("FAIL basic_write%0d: got %h:%h want %h:%h", i,
          got_addr[g0+i], got_data[g0+i], exp_addr[i], exp_data[i]);
      end
    end
    n_checks++;
    if (low_cnt - l0 != 2) begin n_err++; $display("FAIL basic_pulse: low %0d cycles want 2", low_cnt - l0); end
    n_checks++;
    if (o_done !== 1'b1 || o_halt !== 1'b0 || o_word_count !== 3'd2 || o_error !== 1'b0) begin
      n_err++; $display("FAIL basic_run: done=%b halt=%b cnt=%0d err=%b want 1 0 2 0",
        o_done, o_halt, o_word_count, o_error);
    end
  endtask

  task automatic test_gaps();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] q[$];
      int g0 = got_addr.size();
      int l0 = low_cnt;
      int n = 0;
      if (it == 0) q = '{8'h20, 8'h01, 8'h00, 8'h0F, 8'hFC, 8'h00, 8'h00, 8'h00};
      else begin
        for (int k = 0; k < it; k++) push_word(q, rand_plain());
        push_word(q, {6'h3F, 26'($urandom)});
      end
      start_load();
      send_prog(q, 3, 1'b0);
      while (!o_done && n < 200) begin @(negedge clk); n++; end
      n_checks++;
      if (got_addr.size() - g0 != exp_addr.size()) begin
        n_err++; $display("FAIL gaps_nwrites it%0d: got %0d want %0d", it, got_addr.size() - g0, exp_addr.size());
      end else foreach (exp_addr[i]) begin
        n_checks++;
        if (got_addr[g0+i] !== exp_addr[i] || got_data[g0+i] !== exp_data[i]) begin
          n_err++; $display("FAIL gaps_write it%0d w%0d: got %h:%h want %h:%h", it, i,
            got_addr[g0+i], got_data[g0+i], exp_addr[i], exp_data[i]);
        end
      end
      n_checks++;
      if (o_done !== 1'b1 || o_word_count !== 3'(exp_addr.size()) || low_cnt - l0 != 2) begin
        n_err++; $display("FAIL gaps_run it%0d: done=%b cnt=%0d pulse=%0d want 1 %0d 2", it,
          o_done, o_word_count, low_cnt - l0, exp_addr.size());
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    int g0 = got_addr.size();
    int l0 = low_cnt;
    int n = 0;
    for (int k = 0; k < MAXW; k++) push_word(q, rand_plain());
    start_load();
    send_prog(q, 1, 1'b0);
    while (!o_error && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (got_addr.size() - g0 != exp_addr.size() || !exp_err) begin
      n_err++; $display("FAIL ovf_nwrites: got %0d want %0d", got_addr.size() - g0, exp_addr.size());
    end else foreach (exp_addr[i]) begin
      n_checks++;
      if (got_addr[g0+i] !== exp_addr[i] || got_data[g0+i] !== exp_data[i]) begin
        n_err++; $display("FAIL ovf_write%0d: got %h:%h want %h:%h", i,
          got_addr[g0+i], got_data[g0+i], exp_addr[i], exp_data[i]);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_error !== 1'b1 || o_halt !== 1'b1 || o_byte_ready !== 1'b0 || o_word_count !== 3'd4 ||
        low_cnt - l0 != 0) begin
      n_err++; $display("FAIL ovf_state: err=%b halt=%b ready=%b cnt=%0d pulse=%0d want 1 1 0 4 0",
        o_error, o_halt, o_byte_ready, o_word_count, low_cnt - l0);
    end
    start_load();
    n_checks++;
    if (o_error !== 1'b0 || o_inst_addr !== 32'h0) begin
      n_err++; $display("FAIL ovf_restart: err=%b addr=%h want 0 0", o_error, o_inst_addr);
    end
    q.delete();
    push_word(q, rand_plain());
    push_word(q, {6'h3F, 26'($urandom)});
    g0 = got_addr.size();
    n = 0;
    send_prog(q, 2, 1'b0);
    while (!o_done && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (got_addr.size() - g0 != 2 || got_addr[g0] !== 32'h0 || got_data[g0] !== exp_data[0]) begin
      n_err++; $display("FAIL ovf_reload: nwr=%0d first addr=%h want 2 writes from addr 00000000",
        got_addr.size() - g0, (got_addr.size() > g0) ? got_addr[g0] : 32'hX);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int g0;
    int n = 0;
    start_load();
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 1);
    bvalid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_byte_ready, o_we_IF, o_pipe_rst_n, o_halt, o_done, o_error} !== 6'b000100 ||
        o_inst_addr !== 32'h0 || o_instruction_data !== 32'h0 || o_word_count !== 3'd0) begin
      n_err++; $display("FAIL midrst_outputs: flags=%b addr=%h data=%h cnt=%0d want 000100 0 0 0",
        {o_byte_ready, o_we_IF, o_pipe_rst_n, o_halt, o_done, o_error},
        o_inst_addr, o_instruction_data, o_word_count);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    push_word(q, rand_plain());
    push_word(q, {6'h3F, 26'($urandom)});
    g0 = got_addr.size();
    start_load();
    send_prog(q, 2, 1'b0);
    while (!o_done && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (got_addr.size() - g0 != exp_addr.size()) begin
      n_err++; $display("FAIL midrst_nwrites: got %0d want %0d", got_addr.size() - g0, exp_addr.size());
    end else foreach (exp_addr[i]) begin
      n_checks++;
      if (got_addr[g0+i] !== exp_addr[i] || got_data[g0+i] !== exp_data[i]) begin
        n_err++; $display("FAIL midrst_write%0d: got %h:%h want %h:%h", i,
          got_addr[g0+i], got_data[g0+i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_restart_run();
    logic [7:0] q[$];
    int g0;
    int n = 0;
    n_checks++;
    if (o_done !== 1'b1) begin n_err++; $display("FAIL restart_pre: done=%b want 1", o_done); end
    start_load();
    n_checks++;
    if (o_halt !== 1'b1 || o_done !== 1'b0 || o_inst_addr !== 32'h0 || o_word_count !== 3'd0) begin
      n_err++; $display("FAIL restart_state: halt=%b done=%b addr=%h cnt=%0d want 1 0 0 0",
        o_halt, o_done, o_inst_addr, o_word_count);
    end
    push_word(q, rand_plain());
    push_word(q, rand_plain());
    push_word(q, {6'h3F, 26'($urandom)});
    g0 = got_addr.size();
    send_prog(q, 2, 1'b0);
    while (!o_done && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (got_addr.size() - g0 != exp_addr.size()) begin
      n_err++; $display("FAIL restart_nwrites: got %0d want %0d", got_addr.size() - g0, exp_addr.size());
    end else foreach (exp_addr[i]) begin
      n_checks++;
      if (got_addr[g0+i] !== exp_addr[i] || got_data[g0+i] !== exp_data[i]) begin
        n_err++; $display("FAIL restart_write%0d: got %h:%h want %h:%h", i,
          got_addr[g0+i], got_data[g0+i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] q[$] = '{8'h20, 8'h01, 8'h00, 8'h0F, 8'hFC, 8'h00, 8'h00, 8'h00};
    int l0 = low_cnt;
    int g0 = got_addr.size();
    int n = 0;
    start_load();
    send_prog(q, 1, 1'b1);
    while (!o_error && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_error !== 1'b1 || o_done !== 1'b0 || low_cnt - l0 != 0 || got_addr.size() - g0 != 2) begin
      n_err++; $display("FAIL cksum_bad: err=%b done=%b pulse=%0d nwr=%0d want 1 0 0 2",
        o_error, o_done, low_cnt - l0, got_addr.size() - g0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_reset_mid();
    test_restart_run();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
